// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for a seven-segment scan bus: rebuilds 4-digit BCD frames
// from the strobed digit bus and converts each accepted frame to a 14-bit binary value.
module ssd_scan_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_select,
  input  logic [3:0]  display_out,
  output logic [3:0]  ones_o,
  output logic [3:0]  tens_o,
  output logic [3:0]  hundreds_o,
  output logic [3:0]  thousands_o,
  output logic        frame_valid,
  output logic [13:0] value_o,
  output logic        value_valid,
  output logic        seq_error,
  output logic        bcd_error
);

  typedef enum logic [1:0] {HUNT, GOT1, GOT2, GOT3} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sh0, sh1, sh2;
  logic        legal;
  logic [1:0]  idx;
  logic        ld0, ld1, ld2, frame_ok, bcd_bad, seq_bad;

  // vld_pipe[k] set means conversion step k+1 happens at the next edge
  logic [3:0]  vld_pipe;
  logic [13:0] acc, acc_next;
  logic [3:0]  conv_digit;

  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (digit_select)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ld0      = 1'b0;
    ld1      = 1'b0;
    ld2      = 1'b0;
    frame_ok = 1'b0;
    bcd_bad  = 1'b0;
    seq_bad  = 1'b0;
    if (!legal) begin
      seq_bad = 1'b1;
      state_d = HUNT;
    end else if (idx == 2'd0) begin
      // a ones strobe always (re)starts a frame, so a stuck transmitter is silent
      ld0     = 1'b1;
      state_d = GOT1;
    end else begin
      state_d = HUNT;
      if (state_q == GOT1 && idx == 2'd1) begin
        ld1     = 1'b1;
        state_d = GOT2;
      end else if (state_q == GOT2 && idx == 2'd2) begin
        ld2     = 1'b1;
        state_d = GOT3;
      end else if (state_q == GOT3 && idx == 2'd3) begin
        if (sh0 <= 4'd9 && sh1 <= 4'd9 && sh2 <= 4'd9 && display_out <= 4'd9)
          frame_ok = 1'b1;
        else
          bcd_bad = 1'b1;
      end else begin
        seq_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      sh0     <= 4'd0;
      sh1     <= 4'd0;
      sh2     <= 4'd0;
    end else begin
      state_q <= state_d;
      if (ld0) sh0 <= display_out;
      if (ld1) sh1 <= display_out;
      if (ld2) sh2 <= display_out;
    end
  end

  always_comb begin
    conv_digit = ones_o;
    if (vld_pipe[0])      conv_digit = thousands_o;
    else if (vld_pipe[1]) conv_digit = hundreds_o;
    else if (vld_pipe[2]) conv_digit = tens_o;
  end

  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, conv_digit};

  // conversion reads the latched digits, so it overlaps capture of the next frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ones_o      <= 4'd0;
      tens_o      <= 4'd0;
      hundreds_o  <= 4'd0;
      thousands_o <= 4'd0;
      frame_valid <= 1'b0;
      value_o     <= 14'd0;
      value_valid <= 1'b0;
      seq_error   <= 1'b0;
      bcd_error   <= 1'b0;
      vld_pipe    <= 4'd0;
      acc         <= 14'd0;
    end else begin
      frame_valid <= frame_ok;
      seq_error   <= seq_bad;
      bcd_error   <= bcd_bad;
      value_valid <= vld_pipe[3];
      if (vld_pipe[3]) value_o <= acc_next;
      if (frame_ok) begin
        ones_o      <= sh0;
        tens_o      <= sh1;
        hundreds_o  <= sh2;
        thousands_o <= display_out;
        vld_pipe    <= 4'b0001;
        acc         <= 14'd0;
      end else begin
        vld_pipe <= {vld_pipe[2:0], 1'b0};
        if (|vld_pipe) acc <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder: stimulus pushes expected per-cycle events,
// a negedge monitor merges and checks them against DUT pulses and held outputs.
module tb_ssd_scan_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  digit_select, display_out;
  logic [3:0]  ones_o, tens_o, hundreds_o, thousands_o;
  logic        frame_valid, value_valid, seq_error, bcd_error;
  logic [13:0] value_o;

  ssd_scan_decoder dut (
    .clock(clock), .reset(reset),
    .digit_select(digit_select), .display_out(display_out),
    .ones_o(ones_o), .tens_o(tens_o), .hundreds_o(hundreds_o), .thousands_o(thousands_o),
    .frame_valid(frame_valid), .value_o(value_o), .value_valid(value_valid),
    .seq_error(seq_error), .bcd_error(bcd_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        fv, vv, se, be;
    logic        chk_d;
    logic [15:0] d;       // {thousands, hundreds, tens, ones}
    logic        chk_v;
    logic [13:0] v;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  t = 0;   // posedges seen by the driver
  int  k = 0;   // negedges seen by the monitor; negedge k follows posedge k

  function automatic ev_t mk(int c);
    ev_t e;
    e.cyc = c; e.fv = 0; e.vv = 0; e.se = 0; e.be = 0;
    e.chk_d = 0; e.d = 16'd0; e.chk_v = 0; e.v = 14'd0;
    return e;
  endfunction

  task automatic drv(input logic [3:0] sel, input logic [3:0] d);
    digit_select = sel;
    display_out  = d;
    @(posedge clock);
    t++;
    #1;
  endtask

  task automatic push_fv(input logic [15:0] d);
    ev_t e;
    e = mk(t); e.fv = 1; e.chk_d = 1; e.d = d;
    q.push_back(e);
  endtask

  task automatic push_vv(input int c, input logic [13:0] v);
    ev_t e;
    e = mk(c); e.vv = 1; e.chk_v = 1; e.v = v;
    q.push_back(e);
  endtask

  task automatic push_err(input logic se, input logic be);
    ev_t e;
    e = mk(t); e.se = se; e.be = be;
    q.push_back(e);
  endtask

  task automatic push_hold(input int c, input logic [15:0] d, input logic [13:0] v);
    ev_t e;
    e = mk(c); e.chk_d = 1; e.d = d; e.chk_v = 1; e.v = v;
    q.push_back(e);
  endtask

  // full scan, ones first; expected value is hand-computed by the caller
  task automatic frame(input logic [3:0] th, input logic [3:0] h, input logic [3:0] te,
                       input logic [3:0] o, input logic [13:0] v);
    drv(4'b1110, o);
    drv(4'b1101, te);
    drv(4'b1011, h);
    drv(4'b0111, th);
    push_fv({th, h, te, o});
    push_vv(t + 4, v);
  endtask

  always @(negedge clock) begin
    logic       e_fv, e_vv, e_se, e_be, e_cd, e_cv, bad;
    logic [15:0] e_d, a_d;
    logic [13:0] e_v;
    k++;
    e_fv = 0; e_vv = 0; e_se = 0; e_be = 0; e_cd = 0; e_cv = 0; e_d = 0; e_v = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == k) begin
        e_fv |= q[i].fv; e_vv |= q[i].vv; e_se |= q[i].se; e_be |= q[i].be;
        if (q[i].chk_d) begin e_cd = 1; e_d = q[i].d; end
        if (q[i].chk_v) begin e_cv = 1; e_v = q[i].v; end
        q.delete(i);
      end
    end
    a_d = {thousands_o, hundreds_o, tens_o, ones_o};
    if (e_fv | e_vv | e_se | e_be | e_cd | e_cv |
        frame_valid | value_valid | seq_error | bcd_error) begin
      n_vec++;
      bad = 0;
      if ({frame_valid, value_valid, seq_error, bcd_error} != {e_fv, e_vv, e_se, e_be}) begin
        $display("FAIL pulses cyc%0d fv/vv/se/be got %b exp %b", k,
                 {frame_valid, value_valid, seq_error, bcd_error}, {e_fv, e_vv, e_se, e_be});
        bad = 1;
      end
      if (e_cd && a_d !== e_d) begin
        $display("FAIL digits cyc%0d got %h exp %h", k, a_d, e_d);
        bad = 1;
      end
      if (e_cv && value_o !== e_v) begin
        $display("FAIL value cyc%0d got %0d exp %0d", k, value_o, e_v);
        bad = 1;
      end
      if (bad) n_err++;
    end
  end

  initial begin
    reset = 1'b0;
    digit_select = 4'b1111;
    display_out  = 4'd0;
    push_hold(2, 16'h0000, 14'd0);
    repeat (3) drv(4'b1111, 4'd0);
    reset = 1'b1;

    // continuous scan 1234, back-to-back frames
    repeat (3) frame(4'd1, 4'd2, 4'd3, 4'd4, 14'd1234);
    // 9999 then 0000 back-to-back
    frame(4'd9, 4'd9, 4'd9, 4'd9, 14'd9999);
    frame(4'd0, 4'd0, 4'd0, 4'd0, 14'd0);
    // transmitter stuck on ones strobe, then released
    repeat (10) drv(4'b1110, 4'd7);
    frame(4'd8, 4'd6, 4'd5, 4'd7, 14'd8657);
    // skipped hundreds strobe
    drv(4'b1110, 4'd1); drv(4'b1101, 4'd2); drv(4'b0111, 4'd3);
    push_err(1, 0);
    // illegal all-low select mid-frame, then recovery
    drv(4'b1110, 4'd5); drv(4'b1101, 4'd5); drv(4'b0000, 4'd0);
    push_err(1, 0);
    frame(4'd4, 4'd3, 4'd2, 4'd1, 14'd4321);
    // non-BCD tens digit: outputs keep the previous frame
    frame(4'd1, 4'd2, 4'd3, 4'd4, 14'd1234);
    drv(4'b1110, 4'd4); drv(4'b1101, 4'hA); drv(4'b1011, 4'd2); drv(4'b0111, 4'd1);
    push_err(0, 1);
    push_hold(t + 4, 16'h1234, 14'd1234);
    repeat (5) drv(4'b1110, 4'd0);
    // reset two cycles into conversion
    frame(4'd9, 4'd8, 4'd7, 4'd6, 14'd9876);
    drv(4'b1110, 4'd0); drv(4'b1110, 4'd0);
    reset = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc >= t) q.delete(i);
    push_hold(t, 16'h0000, 14'd0);
    push_hold(t + 1, 16'h0000, 14'd0);
    drv(4'b1110, 4'd0); drv(4'b1110, 4'd0);
    reset = 1'b1;
    repeat (6) drv(4'b1110, 4'd3);
    push_hold(t, 16'h0000, 14'd0);
    frame(4'd5, 4'd6, 4'd7, 4'd8, 14'd5678);
    repeat (6) drv(4'b1110, 4'd0);

    n_vec++;
    if (q.size() != 0) begin
      $display("FAIL drain pending events got %0d exp 0", q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
